// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: sequences inst_w/flush for one WS or OS job on the MAC tile array, stalling on an empty L0 FIFO.
// Ports: clk, reset (async, active-low); start/mode/exec_len job request sampled in IDLE;
// l0_empty from the L0 FIFO; inst_w {mode, exec, load} to row 0; flush to all tiles;
// act_rd pops L0; busy is high outside IDLE; done pulses once at job end.
module mac_array_ctrl #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int len_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [len_bw-1:0] exec_len,
    input  logic              l0_empty,
    output logic [2:0]        inst_w,
    output logic              flush,
    output logic              act_rd,
    output logic              busy,
    output logic              done
);
    localparam int CW = ((len_bw > $clog2(row + col)) ? len_bw : $clog2(row + col)) + 1;
    localparam logic [CW-1:0] ROW_M1 = CW'(row - 1);
    localparam logic [CW-1:0] DRN_M1 = CW'(row + col - 2);
    typedef enum logic [2:0] {IDLE, LOAD, GAP, EXEC, DRAIN, FLUSH, DONE} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [len_bw-1:0] len_q;
    logic mode_q, feed, last, nxt_mode;
    logic [2:0] inst_q;
    always_comb begin
        feed     = (state == LOAD) || (state == EXEC);
        act_rd   = feed && !l0_empty;
        last     = (cnt == '0);
        nxt_mode = (state == IDLE) ? mode : mode_q;
        nxt      = state;
        nxt_cnt  = cnt;
        case (state)
            IDLE: if (start) begin
                nxt     = !mode ? LOAD : (exec_len == '0) ? DRAIN : EXEC;
                nxt_cnt = !mode ? ROW_M1 : (exec_len == '0) ? DRN_M1 : CW'(exec_len) - CW'(1);
            end
            LOAD: if (!l0_empty) begin
                nxt     = last ? GAP : LOAD;
                nxt_cnt = last ? '0 : cnt - CW'(1);
            end
            GAP: begin
                nxt     = (len_q == '0) ? DRAIN : EXEC;
                nxt_cnt = (len_q == '0) ? DRN_M1 : CW'(len_q) - CW'(1);
            end
            EXEC: if (!l0_empty) begin
                nxt     = last ? DRAIN : EXEC;
                nxt_cnt = last ? DRN_M1 : cnt - CW'(1);
            end
            DRAIN: begin
                nxt     = last ? (mode_q ? FLUSH : DONE) : DRAIN;
                nxt_cnt = last ? (mode_q ? ROW_M1 : '0) : cnt - CW'(1);
            end
            FLUSH: begin
                nxt     = last ? DONE : FLUSH;
                nxt_cnt = last ? '0 : cnt - CW'(1);
            end
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    // Load/exec bits come from the registered decode, but a stall must blank them in the same cycle.
    assign inst_w = {inst_q[2], inst_q[1:0] & {2{!l0_empty}}};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
            len_q  <= '0;
            inst_q <= '0;
            flush  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= nxt;
            cnt    <= nxt_cnt;
            if (state == IDLE && start) begin
                mode_q <= mode;
                len_q  <= exec_len;
            end
            inst_q <= {nxt_mode && (nxt inside {LOAD, GAP, EXEC, DRAIN, FLUSH}), nxt == EXEC, nxt == LOAD};
            flush  <= nxt == FLUSH;
            busy   <= nxt != IDLE;
            done   <= nxt == DONE;
        end
    end
endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencer for the `row` x `col` MAC tile array. It drives the west-edge instruction bus `inst_w[2:0]` and the array-wide `flush` line through one complete job. In weight-stationary (WS) mode a job is kernel load, then execute, then drain. In output-stationary (OS) mode a job is execute, then drain, then flush. The block sits between the top-level core FSM (`start`/`done`) and the L0 activation FIFO (`l0_empty`/`act_rd`), and it stalls the array whenever L0 runs dry.

## Interface
- `row`, default 8: array rows; sets kernel-load length and flush length.
- `col`, default 8: array columns; with `row`, sets drain length.
- `len_bw`, default 8: width of the execute-length field.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. Low forces IDLE and clears all registers immediately.
- `start` input 1: one-cycle job request; sampled only in IDLE.
- `mode` input 1: job mode, 0 = WS, 1 = OS; latched with `start`.
- `exec_len` input `len_bw`: number of valid execute cycles; latched with `start`.
- `l0_empty` input 1: L0 FIFO has no vector to supply this cycle.
- `inst_w` output 3: bit 2 = mode, bit 1 = execute, bit 0 = kernel load; drives row 0 tile inputs.
- `flush` output 1: OS psum flush, broadcast to all tiles.
- `act_rd` output 1: pop L0 this cycle.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at job end.

## Operation
- States: IDLE, LOAD, GAP, EXEC, DRAIN, FLUSH, DONE.
- One down-counter `cnt`, width max(`len_bw`, clog2(`row`+`col`)) + 1, is reloaded on every state entry.
- `mode_q` and `len_q` are latched on an accepted `start`.
- `inst_w[2]` equals `mode_q` in every state except IDLE and DONE, where it is 0.

Transitions:
- **IDLE:** on `start`, go to LOAD if WS, or to EXEC if OS. If `exec_len` = 0 and OS, go directly to DRAIN. `start` outside IDLE is ignored and is not queued.
- **LOAD (WS only):** `inst_w[1:0]`=01 and `act_rd`=1 for `row` non-stalled cycles, then go to GAP.
- **GAP (WS only):** one cycle with `inst_w[1:0]`=00, so the tiles see the end of load. Then go to EXEC, or to DRAIN if `len_q` = 0.
- **EXEC:** `inst_w[1:0]`=10 and `act_rd`=1 for `len_q` non-stalled cycles, then go to DRAIN.
- **DRAIN:** `inst_w[1:0]`=00 for `row`+`col`-1 cycles; this lets skewed data clear the array. Then go to DONE if WS, or to FLUSH if OS.
- **FLUSH (OS only):** `flush`=1 and `inst_w[1:0]`=00 for `row` cycles, then go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE.

Stall rule:
- In LOAD and EXEC, when `l0_empty`=1: force `inst_w[1:0]`=00 and `act_rd`=0, and hold `cnt`.
- `l0_empty` is ignored in all other states.
- `act_rd` is never high while `l0_empty`=1.

## Timing
- `inst_w`, `flush`, `busy` and `done` are registered, decoded from the next state.
- `act_rd` is combinational: the state's `act_rd` term AND NOT `l0_empty`.
- Reset values: all outputs 0 and state IDLE.
- Latency: `start` sampled at edge N puts the first LOAD/EXEC value on `inst_w` after edge N+1... more precisely, it is visible during cycle N+1.
- WS job, no stalls: `done` is high in cycle 1 + `row` + 1 + `len_q` + (`row`+`col`-1) after the `start` edge.
- OS job, no stalls: `done` is high in cycle 1 + `len_q` + (`row`+`col`-1) + `row` after the `start` edge.
- Each stall cycle adds exactly one cycle.
- `reset` low mid-job aborts the job: outputs clear asynchronously, with no `done` pulse.
- `done` and `start` in the same cycle: `start` is ignored, because the block is not yet in IDLE.

## Test plan
- **WS clean job:** `row`=`col`=8, `exec_len`=16, `l0_empty`=0.
  - LOAD: `inst_w`=001 for cycles 1-8; GAP: 000 in cycle 9; EXEC: 010 for cycles 10-25; DRAIN: 000 for cycles 26-40.
  - `done` in cycle 41; `act_rd` count = 24; `busy` is high for cycles 1-41.
- **WS stall:** as above, with `l0_empty`=1 for 3 cycles mid-EXEC.
  - `inst_w[1]` drops in exactly those cycles; `act_rd` count stays 24; `done` moves to cycle 44.
- **OS job:** `exec_len`=10.
  - `inst_w`=110 for cycles 1-10, then 100 for cycles 11-25 (drain).
  - `flush`=1 for cycles 26-33; `done` in cycle 34; `inst_w[0]` is never 1.
- **Zero length:** `exec_len`=0.
  - WS: EXEC is skipped and `done` is in cycle 25.
  - OS: there are no execute cycles and `done` is in cycle 24.
- **`start` while busy:** pulse `start` in cycles 5 and 41 of a WS job.
  - Exactly one job completes; `done` pulses once.
- **Async reset mid-EXEC:** drop `reset` between clock edges.
  - `inst_w`, `flush`, `act_rd`, `busy` go to 0 before the next edge.
  - No `done` pulse; a new `start` after release runs a full job.
